// File: rtl/rx_packet_ctrl_if.sv
// RX packet controller port bundle: FWFT FIFO read side plus the downstream
// valid/ready payload stream. master = controller, slave = FIFO/consumer side.
interface rx_packet_ctrl_if;
  logic [8:0] fifoData;
  logic       fifoEmpty;
  logic       fifoReadEn;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       outLast;

  modport master (
    input  fifoData, fifoEmpty, outReady,
    output fifoReadEn, outData, outValid, outLast
  );

  modport slave (
    output fifoData, fifoEmpty, outReady,
    input  fifoReadEn, outData, outValid, outLast
  );
endinterface

// File: rtl/rx_packet_ctrl.sv
// Read-side controller for the RX FWFT FIFO: parses SOF/LEN/payload/CHK packets,
// forwards payload with zero latency. Optional counters: RX_PKT_STATS_EN.
module rx_packet_ctrl #(
  parameter int unsigned MAX_LEN        = 64,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                    CLK100MHZ,
  input  logic                    resetN,
  rx_packet_ctrl_if.master        rx,
  output logic                    pktDone,
  output logic                    pktError,
  output logic [1:0]              errCode,
  output logic [15:0]             pktCount,
  output logic [15:0]             errCount
);

  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_FRAME   = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_CHK     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } state_e;

  state_e             state_q, state_d;
  logic               run_q;
  logic [7:0]         remain_q, remain_d;
  logic [7:0]         sum_q, sum_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic [7:0]         head_byte;
  logic               head_ferr;
  logic               head_avail;
  logic               in_payload;
  logic               fwd_valid;
  logic               pop;
  logic               len_ok;
  logic [7:0]         chk_sum;
  logic [TMO_W-1:0]   tmo_inc;
  logic               tmo_hit;

  // Head decode and zero-latency forwarding; everything gated by run_q.
  assign head_byte  = rx.fifoData[7:0];
  assign head_ferr  = rx.fifoData[8];
  assign head_avail = run_q & ~rx.fifoEmpty;
  assign in_payload = (state_q == ST_PAYLOAD);
  assign fwd_valid  = head_avail & in_payload & ~head_ferr;
  // Payload heads pop only on a handshake, except flagged bytes which are dropped.
  assign pop        = in_payload ? ((fwd_valid & rx.outReady) | (head_avail & head_ferr))
                                 : head_avail;

  assign rx.fifoReadEn = pop;
  assign rx.outValid   = fwd_valid;
  assign rx.outData    = run_q ? head_byte : 8'h00;
  assign rx.outLast    = fwd_valid & (remain_q == 8'd1);

  assign len_ok  = (head_byte != 8'd0) && (head_byte <= MAX_LEN_B);
  assign chk_sum = sum_q + head_byte;
  assign tmo_inc = tmo_q + TMO_W'(1);
  assign tmo_hit = (tmo_inc == TMO_W'(TIMEOUT_CYCLES));

  // Next-state, packet bookkeeping and status decisions.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;

    case (state_q)
      ST_IDLE: begin
        if (pop && !head_ferr && (head_byte == SOF_BYTE)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (pop) begin
          if (head_ferr) begin
            err_d   = 1'b1;
            code_d  = ERR_FRAME;
            state_d = ST_IDLE;
          end else if (!len_ok) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end else begin
            remain_d = head_byte;
            sum_d    = head_byte;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pop) begin
          if (head_ferr) begin
            err_d   = 1'b1;
            code_d  = ERR_FRAME;
            state_d = ST_IDLE;
          end else begin
            sum_d    = chk_sum;
            remain_d = remain_q - 8'd1;
            if (remain_q == 8'd1) state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (pop) begin
          state_d = ST_IDLE;
          if (head_ferr) begin
            err_d  = 1'b1;
            code_d = ERR_FRAME;
          end else if (chk_sum == 8'd0) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte timeout: only starvation counts, not downstream backpressure.
    if ((state_q == ST_IDLE) || pop) begin
      tmo_d = '0;
    end else if (rx.fifoEmpty) begin
      tmo_d = tmo_inc;
      if (tmo_hit) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = ST_IDLE;
        tmo_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      remain_q <= 8'd0;
      sum_q    <= 8'd0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      remain_q <= remain_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign pktDone  = done_q;
  assign pktError = err_q;
  assign errCode  = code_q;

`ifdef RX_PKT_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating counters, updated together with the pulse they count.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (done_d && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_d = pkt_cnt_q + 16'd1;
    if (err_d && (err_cnt_q != 16'hFFFF))  err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK100MHZ or negedge resetN) begin
    if (!resetN) begin
      pkt_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pktCount = pkt_cnt_q;
  assign errCount = err_cnt_q;
`else
  assign pktCount = 16'h0000;
  assign errCount = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Bench for rx_packet_ctrl: FIFO model + stream-position reference model checked
// every cycle, directed packets with literal expectations, then random traffic.
module tb_rx_packet_ctrl;
  localparam int unsigned MAX_LEN = 64;
  localparam logic [7:0]  SOF     = 8'hA5;
  localparam int unsigned TMO     = 40;
`ifdef RX_PKT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic        pktDone, pktError;
  logic [1:0]  errCode;
  logic [15:0] pktCount, errCount;

  rx_packet_ctrl_if rx();

  rx_packet_ctrl #(.MAX_LEN(MAX_LEN), .SOF_BYTE(SOF), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK100MHZ(clk),
    .resetN   (resetN),
    .rx       (rx.master),
    .pktDone  (pktDone),
    .pktError (pktError),
    .errCode  (errCode),
    .pktCount (pktCount),
    .errCount (errCount)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // FIFO contents and stimulus controls
  logic [8:0] fifo_q[$];
  bit         pop_seen  = 1'b0;
  bit         rst_n_drv = 1'b0;
  int         ready_mode = 1;   // 0 low, 1 high, 2 random

  // Observation logs (from DUT outputs) for literal checks
  logic [63:0] hs_sig;  int hs_n;
  logic [63:0] err_sig; int err_n;
  int          done_n;
  int          last_pop_cyc, err_cyc;

  task automatic clear_logs();
    hs_sig = '0; hs_n = 0; err_sig = '0; err_n = 0; done_n = 0;
  endtask

  // Reference model: position within the packet stream.
  // pos 0 hunt SOF, 1 expect LEN, 2..len+1 payload, len+2 checksum.
  bit          m_run;
  int          m_pos, m_len, m_sum, m_idle;
  bit          m_done, m_err;
  int          m_code, m_pcnt, m_ecnt;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_len = 0; m_sum = 0; m_idle = 0;
    m_done = 0; m_err = 0; m_code = 0; m_pcnt = 0; m_ecnt = 0;
  endtask

  initial begin : compare
    bit head, fl, in_pay, e_valid, e_pop, e_last, nd, ne;
    int b, nc;
    model_reset();
    clear_logs();
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (!resetN) model_reset();
      head    = m_run && !rx.fifoEmpty;
      fl      = rx.fifoData[8];
      b       = int'(rx.fifoData[7:0]);
      in_pay  = (m_pos >= 2) && (m_pos < m_len + 2);
      e_valid = head && in_pay && !fl;
      e_pop   = head && (!in_pay || fl || rx.outReady);
      e_last  = e_valid && (m_pos == m_len + 1);

      chk("fifoReadEn", rx.fifoReadEn, e_pop);
      chk("outValid",   rx.outValid,   e_valid);
      chk("outLast",    rx.outLast,    e_last);
      if (e_valid)     chk("outData", rx.outData, b);
      else if (!m_run) chk("outData_gated", rx.outData, 0);
      chk("pktDone",  pktDone,  m_done);
      chk("pktError", pktError, m_err);
      chk("errCode",  errCode,  m_code);
      chk("pktCount", pktCount, m_pcnt);
      chk("errCount", errCount, m_ecnt);

      if (rx.outValid && rx.outReady) begin hs_sig = (hs_sig << 8) | 64'(rx.outData); hs_n++; end
      if (pktDone) done_n++;
      if (pktError) begin err_sig = (err_sig << 2) | 64'(errCode); err_n++; err_cyc = cyc; end
      if (rx.fifoReadEn) last_pop_cyc = cyc;
      pop_seen = rx.fifoReadEn;

      if (resetN) begin
        nd = 0; ne = 0; nc = m_code;
        if (e_pop) begin
          m_idle = 0;
          if (m_pos == 0) begin
            if (!fl && b == int'(SOF)) m_pos = 1;
          end else if (fl) begin
            ne = 1; nc = 1; m_pos = 0;
          end else if (m_pos == 1) begin
            if (b == 0 || b > int'(MAX_LEN)) begin ne = 1; nc = 2; m_pos = 0; end
            else begin m_len = b; m_sum = b; m_pos = 2; end
          end else if (in_pay) begin
            m_sum = (m_sum + b) % 256; m_pos++;
          end else begin
            if ((m_sum + b) % 256 == 0) nd = 1;
            else begin ne = 1; nc = 3; end
            m_pos = 0;
          end
        end else if (m_pos != 0 && rx.fifoEmpty) begin
          m_idle++;
          if (m_idle == int'(TMO)) begin ne = 1; nc = 0; m_pos = 0; end
        end
        if (m_pos == 0) m_idle = 0;
        if (STATS && nd && m_pcnt < 65535) m_pcnt++;
        if (STATS && ne && m_ecnt < 65535) m_ecnt++;
        m_done = nd; m_err = ne; m_code = nc; m_run = 1;
      end
    end
  end

  // One cycle of FIFO/consumer behaviour, driven on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    resetN       = rst_n_drv;
    rx.fifoEmpty = (fifo_q.size() == 0);
    rx.fifoData  = rx.fifoEmpty ? 9'($urandom) : fifo_q[0];
    rx.outReady  = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [8:0] v);
    fifo_q.push_back(v);
  endtask

  task automatic push_pkt(input logic [7:0] len, input logic [7:0] chk_byte, input bit flag_at_end);
    push({1'b0, SOF});
    push({1'b0, len});
    for (int i = 0; i < int'(len); i++) push({1'b0, 8'($urandom)});
    push({flag_at_end, chk_byte});
  endtask

  initial begin : driver
    logic [7:0] len, s, v;
    int kind;
    resetN = 1'b0; rx.fifoEmpty = 1'b1; rx.fifoData = '0; rx.outReady = 1'b0;
    ticks(3);
    chk("reset_pktDone",  pktDone,  0);
    chk("reset_errCode",  errCode,  0);
    rst_n_drv = 1'b1;
    ticks(2);

    // Good packet
    clear_logs(); ready_mode = 1;
    push(9'h0A5); push(9'h003); push(9'h011); push(9'h022); push(9'h033); push(9'h097);
    ticks(12);
    chk("good_payload", hs_sig, 64'h112233);
    chk("good_nbytes",  hs_n, 3);
    chk("good_done",    done_n, 1);
    chk("good_noerr",   err_n, 0);
    chk("good_pktCount", pktCount, STATS ? 1 : 0);

    // Bad checksum
    clear_logs();
    push(9'h0A5); push(9'h002); push(9'h010); push(9'h020); push(9'h000);
    ticks(10);
    chk("badchk_payload", hs_sig, 64'h1020);
    chk("badchk_errs",    {32'(err_n), err_sig[31:0]}, {32'd1, 32'h3});
    chk("badchk_errCount", errCount, STATS ? 1 : 0);

    // Bad lengths: zero and MAX_LEN+1
    clear_logs();
    push(9'h0A5); push(9'h000); push(9'h0A5); push(9'h041);
    ticks(10);
    chk("badlen_errs",   {32'(err_n), err_sig[31:0]}, {32'd2, 32'hA});
    chk("badlen_nbytes", hs_n, 0);

    // Frame error after a backpressured payload byte
    clear_logs(); ready_mode = 0;
    push(9'h0A5); push(9'h004); push(9'h001); push(9'h102);
    ticks(8);
    chk("stall_fifo_level", fifo_q.size(), 2);
    chk("stall_nbytes",     hs_n, 0);
    ready_mode = 1;
    ticks(6);
    chk("frame_payload", {32'(hs_n), hs_sig[31:0]}, {32'd1, 32'h01});
    chk("frame_errs",    {32'(err_n), err_sig[31:0]}, {32'd1, 32'h1});
    chk("frame_fifo_drained", fifo_q.size(), 0);

    // Timeout, then resync on a fresh packet
    clear_logs();
    push(9'h0A5); push(9'h002); push(9'h055);
    ticks(TMO + 8);
    chk("tmo_errs",    {32'(err_n), err_sig[31:0]}, {32'd1, 32'h0});
    chk("tmo_latency", err_cyc - last_pop_cyc, TMO + 1);
    clear_logs();
    push(9'h000); push(9'h0A5); push(9'h001); push(9'h07F); push(9'h080);
    ticks(10);
    chk("resync_done",    done_n, 1);
    chk("resync_payload", hs_sig, 64'h7F);

    // Async reset mid-payload
    clear_logs(); ready_mode = 0;
    push(9'h0A5); push(9'h005); push(9'h001); push(9'h002);
    ticks(5);
    chk("pre_rst_valid", rx.outValid, 1);
    rst_n_drv = 1'b0;
    tick(); #2;
    chk("rst_outValid",   rx.outValid, 0);
    chk("rst_fifoReadEn", rx.fifoReadEn, 0);
    chk("rst_outData",    rx.outData, 0);
    fifo_q.delete();
    ticks(2);
    rst_n_drv = 1'b1;
    ticks(3);
    chk("rst_nopulse", {32'(err_n), 32'(done_n)}, 64'd0);
    ready_mode = 1;
    push(9'h0A5); push(9'h002); push(9'h040); push(9'h050); push(9'h06E);
    ticks(10);
    chk("post_rst_done",    done_n, 1);
    chk("post_rst_payload", hs_sig, 64'h4050);
    chk("post_rst_pktCount", pktCount, STATS ? 1 : 0);

    // Randomized traffic
    ready_mode = 2;
    for (int p = 0; p < 150; p++) begin
      kind = $urandom_range(0, 5);
      len  = 8'($urandom_range(1, 12));
      if ($urandom_range(0, 9) == 0) len = 8'(MAX_LEN);
      s = len;
      case (kind)
        0, 1: begin
          push({1'b0, SOF}); push({1'b0, len});
          for (int i = 0; i < int'(len); i++) begin
            v = 8'($urandom); s = s + v; push({1'b0, v});
            if ($urandom_range(0, 3) == 0) ticks($urandom_range(1, 3));
            if ($urandom_range(0, 60) == 0) ticks(TMO + 3);
          end
          push({1'b0, 8'(8'd0 - s)});
        end
        2: push_pkt(len, 8'($urandom), 1'b0);
        3: begin
          push({1'b0, SOF});
          push({1'b0, ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255))});
        end
        4: push_pkt(len, 8'($urandom), 1'b1);
        default: for (int i = 0; i < 4; i++) push(9'($urandom));
      endcase
      ticks($urandom_range(0, 4) + int'(len));
    end
    ticks(2 * TMO + 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
